xpb_accum: RTL
==============

# xpb_accum

Streaming accumulator directly downstream of the xpb lookup tables in the modular-squaring reduction path. Accepts one WIDTH-bit xpb term per cycle, keeps the running sum in carry-save form, and on the packet's last term resolves the sum with a segmented carry-propagate adder. It presents the full-width result to the next reduction stage over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 1024: width of each xpb term.
- GUARD, 8: growth bits; result width OUT_W = WIDTH+GUARD.
- SEG_W, 128: bits resolved per cycle by the final adder; NSEG = ceil(OUT_W/SEG_W), which is 9 at defaults.

Ports (one clock; reset is synchronous and active-high):
- clk: input, 1 bit, sole clock; all state updates on the rising edge.
- reset: input, 1 bit, synchronous, active-high.
- in_valid: input, 1 bit, term present on in_data.
- in_ready: output, 1 bit, accumulator can take a term.
- in_last: input, 1 bit, qualifies the final term of a packet.
- in_data: input, WIDTH bits, xpb term.
- out_valid: output, 1 bit, result available.
- out_ready: input, 1 bit, consumer accepts the result.
- out_data: output, OUT_W bits, resolved sum.
- out_count: output, GUARD+1 bits, number of terms in the result.
- out_ovf: output, 1 bit, term-count overflow (see Configuration).

## Operation
- States: ACCUM, RESOLVE, DONE. Reset enters ACCUM with first=1, count=0, and sum/carry registers cleared.
- ACCUM: in_ready=1. A term is accepted when in_valid&in_ready.
  - On the first term of a packet: sum←in_data zero-extended, carry←0, count←1.
  - On later terms: sum←sum^carry^d and carry←maj(sum,carry,d)<<1, all truncated to OUT_W. Count is incremented.
  - An accepted term with in_last=1 moves to RESOLVE with seg=0.
- RESOLVE: in_ready=0. Each cycle adds sum[seg]+carry[seg]+cin into result segment seg. The carry-out is registered as cin for the next segment; cin=0 for seg 0. seg increments each cycle.
  - The top segment is OUT_W−(NSEG−1)·SEG_W bits wide, and its carry-out is discarded.
  - After segment NSEG−1 is written, the block moves to DONE.
- DONE: out_valid=1, in_ready=0. out_data, out_count and out_ovf stay stable until out_valid&out_ready. On the handshake: return to ACCUM, first←1.
- Arithmetic: out_data = (Σ terms) mod 2^OUT_W. The result is exact when count ≤ 2^GUARD.
- A single-term packet (in_last on the first beat) gives out_data = the term.
- in_valid with in_last=0 is the only way to grow a packet. There is no packet limit other than the count saturating at 2^(GUARD+1)−1.
- Reset in any state, including mid-RESOLVE or DONE with out_valid high: the packet is discarded, the block enters ACCUM, and out_valid=0 on the next cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_count=0, out_ovf=0.
- Input throughput: one term per cycle in ACCUM; there is no bubble between terms.
- Latency: if the last term is accepted at edge E0, out_valid is high after edge E0+NSEG. That is 9 cycles at defaults.
- Minimum packet-to-packet gap: NSEG+1 cycles when out_ready is held high.
- out_valid does not depend combinationally on out_ready. in_ready is a registered state decode.

## Configuration
- XPB_ACCUM_OVF_EN defined:
  - A sticky flag sets when an accepted term makes count exceed 2^GUARD.
  - The flag is copied to out_ovf with the result and cleared at the start of the next packet.
- XPB_ACCUM_OVF_EN undefined:
  - No overflow logic; out_ovf is tied 0.
  - out_count is still reported.

## Test plan
- Terms 1, 2, 3 (last on 3) with out_ready=1 → out_data=6, out_count=3, out_valid exactly NSEG cycles after the last accept.
- Single term 2^WIDTH−1 with in_last=1 → out_data=2^1024−1, out_count=1.
- Terms 2^1024−1 then 1 → out_data=2^1024 (bit 1024 set). This exercises the carry across all segments.
- 256 terms of 2^1024−1 → out_data=2^1032−256, out_ovf=0. 257 terms → out_ovf=1 with XPB_ACCUM_OVF_EN, 0 without.
- out_ready held low 5 cycles in DONE → out_data and out_valid stable and in_ready=0 throughout. Accept, then the next packet's first term is taken the cycle after.
- reset pulsed at seg=4 of RESOLVE → out_valid stays 0 and in_ready=1 next cycle. A new packet (7 last) then gives out_data=7.

Source files
------------

// File: rtl/xpb_accum.sv
// xpb_accum -- streaming carry-save accumulator for xpb lookup terms.
//
// Takes one WIDTH-bit term per cycle. The running sum is kept as a
// sum/carry pair, so accepting a term never waits on a long carry chain.
// On the packet's last term, a segmented adder resolves the pair SEG_W bits
// per cycle, from least significant to most significant. The result is then
// held on a valid/ready output.
//
// Optional feature macro: XPB_ACCUM_OVF_EN
//   Defined:   out_ovf reports that the packet held more than 2^GUARD terms.
//              Past that point the sum may have wrapped.
//   Undefined: out_ovf is tied low. out_count is still reported.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high; discards any packet in flight
//   in_valid   term present on in_data
//   in_ready   accumulator can take a term (high only while accumulating)
//   in_last    marks the final term of a packet
//   in_data    WIDTH-bit xpb term
//   out_valid  resolved result available
//   out_ready  consumer accepts the result
//   out_data   WIDTH+GUARD-bit resolved sum (modulo 2^(WIDTH+GUARD))
//   out_count  number of terms in the result, saturating at all-ones
//   out_ovf    term-count overflow flag (see macro above)
module xpb_accum #(
  parameter int WIDTH = 1024,
  parameter int GUARD = 8,
  parameter int SEG_W = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+GUARD-1:0] out_data,
  output logic [GUARD:0]         out_count,
  output logic                   out_ovf
);

  localparam int OUT_W  = WIDTH + GUARD;
  localparam int NSEG   = (OUT_W + SEG_W - 1) / SEG_W;
  localparam int SEG_IW = (NSEG > 1) ? $clog2(NSEG + 1) : 1;
  localparam int CNT_W  = GUARD + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              first;
  logic [OUT_W-1:0]  sum;
  logic [OUT_W-1:0]  carry;
  logic [OUT_W-1:0]  res;
  logic [SEG_IW-1:0] seg;
  logic              cin;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              last_seg;
  logic [OUT_W-1:0]  d_ext;
  logic [OUT_W-1:0]  csa_sum;
  logic [OUT_W-1:0]  csa_car;

  int                sh;
  logic [SEG_W-1:0]  seg_a;
  logic [SEG_W-1:0]  seg_b;
  logic [SEG_W:0]    seg_add;
  logic [OUT_W-1:0]  seg_mask;
  logic [OUT_W-1:0]  res_nxt;

  // Saturating term counter: it holds at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign accept   = in_valid & in_ready;
  assign last_seg = (seg == SEG_IW'(NSEG - 1));
  assign d_ext    = OUT_W'(in_data);

  // 3:2 compressor folding the new term into the sum/carry pair.
  assign csa_sum = sum ^ carry ^ d_ext;
  assign csa_car = ((sum & carry) | (sum & d_ext) | (carry & d_ext)) << 1;

  // One segment of the final carry-propagate add. The shift by seg*SEG_W
  // pushes the narrower top segment's unused bits off the end of the
  // OUT_W-wide vectors. Any carry out of the top segment is dropped there.
  always_comb begin
    sh       = int'(seg) * SEG_W;
    seg_a    = SEG_W'(sum >> sh);
    seg_b    = SEG_W'(carry >> sh);
    seg_add  = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, cin};
    seg_mask = OUT_W'({SEG_W{1'b1}}) << sh;
    res_nxt  = (res & ~seg_mask) | ((OUT_W'(seg_add[SEG_W-1:0]) << sh) & seg_mask);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (last_seg) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Stage boundary: the accumulate and resolve registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      first     <= 1'b1;
      count     <= '0;
      sum       <= '0;
      carry     <= '0;
      res       <= '0;
      seg       <= '0;
      cin       <= 1'b0;
      out_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ACCUM: begin
          if (accept) begin
            if (first) begin
              sum   <= d_ext;
              carry <= '0;
              count <= CNT_W'(1);
            end else begin
              sum   <= csa_sum;
              carry <= csa_car;
              count <= sat_inc(count);
            end
            first <= 1'b0;
            if (in_last) begin
              seg <= '0;
              cin <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          res <= res_nxt;
          cin <= seg_add[SEG_W];
          seg <= seg + 1'b1;
          if (last_seg) out_count <= count;
        end
        DONE: begin
          if (out_ready) first <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data = res;

`ifdef XPB_ACCUM_OVF_EN
  localparam logic [CNT_W-1:0] CNT_LIM = {1'b1, {GUARD{1'b0}}};

  logic ovf;

  // The sticky flag restarts with each packet's first term. It is published
  // together with the result when the top segment is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf     <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (accept) begin
        if (first) ovf <= 1'b0;
        else       ovf <= ovf | (sat_inc(count) > CNT_LIM);
      end
      if (state == RESOLVE && last_seg) out_ovf <= ovf;
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule
